// File: rtl/cfg_frame_rx.sv
// cfg_frame_rx: receiver for the configuration frame carried on the slink cfg
// byte stream (10-bit words: [7:0] byte, [8] SOF, [9] EOF, qualified by dval).
// Incoming bytes are parsed into shadow registers. When a frame ends, its
// length and content are validated. A good frame updates every cfg_* field in
// the same cycle. Each rejected frame produces an error pulse and a cause code.
// Consecutive rejects are counted, and a sticky request-failure flag is raised
// when the count reaches REQ_MAX.
//
// Build option: define CFG_CHKSUM_EN to append a checksum byte to the frame.
// The 8-bit sum of all bytes, including the checksum byte, must then be zero.
module cfg_frame_rx #(
    parameter int CHN_NUM   = 12,
    parameter int SLINK_NUM = 2,
    parameter int REQ_MAX   = 5
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic                 self_id_err,
    input  logic                 slink_cfg_dval,
    input  logic [9:0]           slink_cfg_data,
    output logic [31:0]          cfg_md_id,
    output logic [31:0]          cfg_code_rev,
    output logic [CHN_NUM-1:0]   cfg_chn_enable,
    output logic [15:0]          cfg_run_tm,
    output logic [SLINK_NUM-1:0] cfg_slink_chen,
    output logic [7:0]           cfg_com_mode,
    output logic                 cfg_done,
    output logic                 cfg_done_trig,
    output logic                 cfg_frame_err,
    output logic [1:0]           cfg_err_code,
    output logic                 cfg_req_fail
);

    localparam int CHN_BYTES = (CHN_NUM + 7) / 8;
    localparam int DATA_LEN  = 12 + CHN_BYTES;
`ifdef CFG_CHKSUM_EN
    localparam int FRAME_LEN = DATA_LEN + 1;
`else
    localparam int FRAME_LEN = DATA_LEN;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [3:0]       REQ_MAX_C   = 4'(REQ_MAX);

    // Byte offsets of the trailing fields, which shift with CHN_BYTES
    localparam int OFS_CHN   = 8;
    localparam int OFS_RUN   = 8 + CHN_BYTES;
    localparam int OFS_SLINK = 10 + CHN_BYTES;
    localparam int OFS_COM   = 11 + CHN_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;
    localparam logic [1:0] ERR_DATA = 2'd3;

    // Split the incoming stream word into its fields
    logic [7:0] byte_in;
    logic       sof_in;
    logic       eof_in;
    assign byte_in = slink_cfg_data[7:0];
    assign sof_in  = slink_cfg_data[8];
    assign eof_in  = slink_cfg_data[9];

    // ------------------------------------------------------------------
    // self_id_err crosses into clk_sys through a two-flop synchroniser
    // ------------------------------------------------------------------
    logic [1:0] id_sync_q;
    logic       id_err_s;

    // Two-flop synchroniser for the asynchronous self_id_err input
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            id_sync_q <= 2'b00;
        end else begin
            id_sync_q <= {id_sync_q[0], self_id_err};
        end
    end
    assign id_err_s = id_sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM and byte counter
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;      // store byte_in at offset wr_idx
    logic             first_wr;   // the stored byte starts a new frame
    logic [CNT_W-1:0] wr_idx;
    logic             ovr_rej;    // frame filled up without any EOF

    // Next-state logic: SOF always (re)starts at offset 0, so a restart
    // mid-frame silently drops the partial frame
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        first_wr = 1'b0;
        wr_idx   = cnt_q;
        ovr_rej  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slink_cfg_dval && sof_in) begin
                    wr_en    = 1'b1;
                    first_wr = 1'b1;
                    wr_idx   = '0;
                    cnt_d    = CNT_W'(1);
                    state_d  = eof_in ? ST_CHECK : ST_RECV;
                end
            end
            ST_RECV: begin
                if (slink_cfg_dval) begin
                    if (sof_in) begin
                        wr_en    = 1'b1;
                        first_wr = 1'b1;
                        wr_idx   = '0;
                        cnt_d    = CNT_W'(1);
                        state_d  = eof_in ? ST_CHECK : ST_RECV;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = cnt_q;
                        cnt_d  = cnt_q + 1'b1;
                        if (eof_in) begin
                            state_d = ST_CHECK;
                        end else if (cnt_q + 1'b1 == FRAME_LEN_C) begin
                            // A full frame's worth arrived and EOF is still
                            // missing, so the frame is too long
                            ovr_rej = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and byte counter registers
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow byte registers (data bytes only; checksum byte is just summed)
    // ------------------------------------------------------------------
    logic [7:0] sh [DATA_LEN];

    generate
        for (genvar gi = 0; gi < DATA_LEN; gi++) begin : gen_shadow
            logic [7:0] byte_q;

            // Capture the stream byte addressed to this offset
            always_ff @(posedge clk_sys or posedge rst_sys) begin
                if (rst_sys) begin
                    byte_q <= 8'h00;
                end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
                    byte_q <= byte_in;
                end
            end
            assign sh[gi] = byte_q;
        end
    endgenerate

`ifdef CFG_CHKSUM_EN
    // ------------------------------------------------------------------
    // Running 8-bit sum over every stored byte, checksum byte included
    // ------------------------------------------------------------------
    logic [7:0] sum_q, sum_d;

    // Restart the sum on SOF and accumulate on every stored byte
    always_comb begin
        sum_d = sum_q;
        if (first_wr) begin
            sum_d = byte_in;
        end else if (wr_en) begin
            sum_d = sum_q + byte_in;
        end
    end

    // Running checksum register
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Field reassembly from shadow bytes
    // ------------------------------------------------------------------
    logic [31:0]            md_id_sh;
    logic [31:0]            code_rev_sh;
    logic [8*CHN_BYTES-1:0] chn_full;
    logic [15:0]            run_tm_sh;
    logic [7:0]             slink_byte;
    logic [7:0]             com_mode_sh;
    logic                   unused_bits;

    // The two 16-bit halves of each 32-bit field arrive high half second
    assign md_id_sh    = {sh[2], sh[3], sh[0], sh[1]};
    assign code_rev_sh = {sh[6], sh[7], sh[4], sh[5]};
    assign run_tm_sh   = {sh[OFS_RUN], sh[OFS_RUN+1]};
    assign slink_byte  = sh[OFS_SLINK];
    assign com_mode_sh = sh[OFS_COM];

    generate
        for (genvar gi = 0; gi < CHN_BYTES; gi++) begin : gen_chn
            // Channel-enable bytes arrive most significant byte first
            assign chn_full[8*(CHN_BYTES-1-gi) +: 8] = sh[OFS_CHN+gi];
        end
    endgenerate

    // Padding bits above CHN_NUM / SLINK_NUM are received but meaningless
    assign unused_bits = ^{chn_full, slink_byte};

    // ------------------------------------------------------------------
    // Frame validation: length beats checksum beats content
    // ------------------------------------------------------------------
    logic       in_check;
    logic       len_ok;
    logic       sum_ok;
    logic       data_ok;
    logic       commit_s;
    logic       reject_s;
    logic [1:0] rej_code_s;

    assign in_check = (state_q == ST_CHECK);
    assign len_ok   = (cnt_q == FRAME_LEN_C);
`ifdef CFG_CHKSUM_EN
    assign sum_ok   = (sum_q == 8'h00);
`else
    assign sum_ok   = 1'b1;
`endif
    assign data_ok  = (md_id_sh != 32'h0) && (com_mode_sh != 8'h00);
    assign commit_s = in_check && len_ok && sum_ok && data_ok;
    assign reject_s = ovr_rej || (in_check && !commit_s);

    // Reject cause, in priority order
    always_comb begin
        rej_code_s = ERR_DATA;
        if (ovr_rej || !len_ok) begin
            rej_code_s = ERR_LEN;
        end else if (!sum_ok) begin
            rej_code_s = ERR_SUM;
        end
    end

    // ------------------------------------------------------------------
    // Committed configuration, status pulses and failure tracking
    // ------------------------------------------------------------------
    logic [31:0]          md_id_q;
    logic [31:0]          code_rev_q;
    logic [CHN_NUM-1:0]   chn_q;
    logic [15:0]          run_tm_q;
    logic [SLINK_NUM-1:0] slink_q;
    logic [7:0]           com_mode_q;
    logic                 done_q;
    logic                 done_trig_q;
    logic                 frame_err_q;
    logic [1:0]           err_code_q;
    logic                 req_fail_q;
    logic [3:0]           fail_cnt_q;
    logic [3:0]           fail_cnt_d;

    // Consecutive-reject count saturates at REQ_MAX
    assign fail_cnt_d = (fail_cnt_q >= REQ_MAX_C) ? REQ_MAX_C : fail_cnt_q + 4'd1;

    // Atomic commit of all fields, or reject bookkeeping
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            md_id_q     <= '0;
            code_rev_q  <= '0;
            chn_q       <= '0;
            run_tm_q    <= '0;
            slink_q     <= '0;
            com_mode_q  <= '0;
            done_q      <= 1'b0;
            done_trig_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            req_fail_q  <= 1'b0;
            fail_cnt_q  <= 4'd0;
        end else begin
            done_trig_q <= commit_s && !id_err_s;
            frame_err_q <= reject_s;
            if (commit_s) begin
                md_id_q    <= md_id_sh;
                code_rev_q <= code_rev_sh;
                chn_q      <= chn_full[CHN_NUM-1:0];
                run_tm_q   <= run_tm_sh;
                slink_q    <= slink_byte[SLINK_NUM-1:0];
                com_mode_q <= com_mode_sh;
                done_q     <= 1'b1;
                fail_cnt_q <= 4'd0;
            end
            if (reject_s) begin
                err_code_q <= rej_code_s;
                fail_cnt_q <= fail_cnt_d;
                if (fail_cnt_d == REQ_MAX_C) begin
                    req_fail_q <= 1'b1;
                end
            end
        end
    end

    assign cfg_md_id      = md_id_q;
    assign cfg_code_rev   = code_rev_q;
    assign cfg_chn_enable = chn_q;
    assign cfg_run_tm     = run_tm_q;
    assign cfg_slink_chen = slink_q;
    assign cfg_com_mode   = com_mode_q;
    assign cfg_done       = done_q;
    assign cfg_done_trig  = done_trig_q;
    assign cfg_frame_err  = frame_err_q;
    assign cfg_err_code   = err_code_q;
    assign cfg_req_fail   = req_fail_q;

endmodule

// File: tb/tb_cfg_frame_rx.sv
// Directed testbench for cfg_frame_rx (CHN_NUM=12, SLINK_NUM=2, REQ_MAX=5).
// Frame length follows CFG_CHKSUM_EN: 15 bytes with it defined, 14 without.
module tb_cfg_frame_rx;

    localparam int CHN_NUM   = 12;
    localparam int SLINK_NUM = 2;
    localparam int REQ_MAX   = 5;
`ifdef CFG_CHKSUM_EN
    localparam int FL = 15;
`else
    localparam int FL = 14;
`endif

    logic                 clk_sys = 1'b0;
    logic                 rst_sys = 1'b1;
    logic                 self_id_err = 1'b0;
    logic                 slink_cfg_dval = 1'b0;
    logic [9:0]           slink_cfg_data = '0;
    logic [31:0]          cfg_md_id;
    logic [31:0]          cfg_code_rev;
    logic [CHN_NUM-1:0]   cfg_chn_enable;
    logic [15:0]          cfg_run_tm;
    logic [SLINK_NUM-1:0] cfg_slink_chen;
    logic [7:0]           cfg_com_mode;
    logic                 cfg_done;
    logic                 cfg_done_trig;
    logic                 cfg_frame_err;
    logic [1:0]           cfg_err_code;
    logic                 cfg_req_fail;

    cfg_frame_rx #(
        .CHN_NUM   (CHN_NUM),
        .SLINK_NUM (SLINK_NUM),
        .REQ_MAX   (REQ_MAX)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .self_id_err    (self_id_err),
        .slink_cfg_dval (slink_cfg_dval),
        .slink_cfg_data (slink_cfg_data),
        .cfg_md_id      (cfg_md_id),
        .cfg_code_rev   (cfg_code_rev),
        .cfg_chn_enable (cfg_chn_enable),
        .cfg_run_tm     (cfg_run_tm),
        .cfg_slink_chen (cfg_slink_chen),
        .cfg_com_mode   (cfg_com_mode),
        .cfg_done       (cfg_done),
        .cfg_done_trig  (cfg_done_trig),
        .cfg_frame_err  (cfg_frame_err),
        .cfg_err_code   (cfg_err_code),
        .cfg_req_fail   (cfg_req_fail)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int trig_cnt = 0;
    int ferr_cnt = 0;
    int t0;
    int e0;

    logic [7:0] fr [16];

    // Count single-cycle pulses, sampled away from the active edge
    always @(negedge clk_sys) begin
        if (cfg_done_trig) trig_cnt++;
        if (cfg_frame_err) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Fixed fields: code_rev AA BB CC DD, chn 0F A5, run_tm 56 78, slink FE
    task automatic build(input logic [7:0] m0, input logic [7:0] m1,
                         input logic [7:0] m2, input logic [7:0] m3,
                         input logic [7:0] com, input logic [7:0] cadj);
        logic [7:0] s;
        fr[0] = m0; fr[1] = m1; fr[2] = m2; fr[3] = m3;
        fr[4] = 8'hAA; fr[5] = 8'hBB; fr[6] = 8'hCC; fr[7] = 8'hDD;
        fr[8] = 8'h0F; fr[9] = 8'hA5;
        fr[10] = 8'h56; fr[11] = 8'h78;
        fr[12] = 8'hFE; fr[13] = com;
        s = 8'h00;
        for (int i = 0; i < 14; i++) s = s + fr[i];
        fr[14] = (8'h00 - s) + cadj;
        fr[15] = 8'h00;
    endtask

    task automatic send_byte(input bit sof, input bit eof, input logic [7:0] d);
        slink_cfg_dval = 1'b1;
        slink_cfg_data = {eof, sof, d};
        @(negedge clk_sys);
        slink_cfg_dval = 1'b0;
        slink_cfg_data = '0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(i == 0, i == n - 1, fr[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle(3);
        chk("rst_md_id", cfg_md_id, 32'h0);
        chk("rst_code_rev", cfg_code_rev, 32'h0);
        chk("rst_chn", 32'(cfg_chn_enable), 32'h0);
        chk("rst_done", 32'(cfg_done), 32'h0);
        chk("rst_trig", 32'(cfg_done_trig), 32'h0);
        chk("rst_ferr", 32'(cfg_frame_err), 32'h0);
        chk("rst_req_fail", 32'(cfg_req_fail), 32'h0);
        rst_sys = 1'b0;
        idle(2);
        chk("rst_code", 32'(cfg_err_code), 32'h0);

        // ---------------- valid frame A ----------------
        build(8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h00);
        t0 = trig_cnt; e0 = ferr_cnt;
        send_frame(FL);
        chk("A_trig_n1", 32'(cfg_done_trig), 32'h0);
        chk("A_done_n1", 32'(cfg_done), 32'h0);
        @(negedge clk_sys);
        chk("A_trig_n2", 32'(cfg_done_trig), 32'h1);
        chk("A_md_id", cfg_md_id, 32'h5678_1234);
        chk("A_code_rev", cfg_code_rev, 32'hCCDD_AABB);
        chk("A_chn", 32'(cfg_chn_enable), 32'hFA5);
        chk("A_run_tm", 32'(cfg_run_tm), 32'h5678);
        chk("A_slink", 32'(cfg_slink_chen), 32'h2);
        chk("A_com", 32'(cfg_com_mode), 32'h01);
        chk("A_done", 32'(cfg_done), 32'h1);
        @(negedge clk_sys);
        chk("A_trig_n3", 32'(cfg_done_trig), 32'h0);
        idle(2);
        chk("A_trig_cnt", 32'(trig_cnt - t0), 32'd1);
        chk("A_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);

`ifdef CFG_CHKSUM_EN
        // ---------------- bad checksum ----------------
        build(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h01);
        e0 = ferr_cnt; t0 = trig_cnt;
        send_frame(FL);
        idle(3);
        chk("sum_ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
        chk("sum_code", 32'(cfg_err_code), 32'd2);
        chk("sum_md_kept", cfg_md_id, 32'h5678_1234);
        chk("sum_trig_cnt", 32'(trig_cnt - t0), 32'd0);
`endif

        // ---------------- EOF on byte 10 ----------------
        build(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h00);
        e0 = ferr_cnt;
        send_frame(10);
        idle(3);
        chk("short_ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
        chk("short_code", 32'(cfg_err_code), 32'd1);
        chk("short_md_kept", cfg_md_id, 32'h5678_1234);

        // ---------------- md_id == 0 ----------------
        build(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        e0 = ferr_cnt;
        send_frame(FL);
        idle(3);
        chk("md0_ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
        chk("md0_code", 32'(cfg_err_code), 32'd3);

        // ---------------- 16 bytes without EOF ----------------
        e0 = ferr_cnt;
        send_byte(1'b1, 1'b0, 8'h12);
        for (int i = 1; i < 16; i++) send_byte(1'b0, 1'b0, 8'h11);
        idle(3);
        chk("ovr_ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
        chk("ovr_code", 32'(cfg_err_code), 32'd1);
        send_byte(1'b0, 1'b1, 8'h22);
        idle(3);
        chk("ovr_ignored", 32'(ferr_cnt - e0), 32'd1);
        chk("ovr_req_fail", 32'(cfg_req_fail), 32'h0);

        // ---------------- SOF at byte 6 restarts ----------------
        build(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h00);
        e0 = ferr_cnt; t0 = trig_cnt;
        send_byte(1'b1, 1'b0, 8'h55);
        for (int i = 1; i < 6; i++) send_byte(1'b0, 1'b0, 8'h66);
        send_frame(FL);
        idle(3);
        chk("rs_trig_cnt", 32'(trig_cnt - t0), 32'd1);
        chk("rs_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);
        chk("rs_md_id", cfg_md_id, 32'hDEF0_9ABC);
        chk("rs_code_held", 32'(cfg_err_code), 32'd1);

        // ---------------- 5 frames with com_mode 0 ----------------
        build(8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00);
        e0 = ferr_cnt;
        for (int k = 0; k < REQ_MAX; k++) begin
            send_frame(FL);
            idle(3);
            chk($sformatf("com0_%0d_code", k), 32'(cfg_err_code), 32'd3);
            chk($sformatf("com0_%0d_req_fail", k), 32'(cfg_req_fail), (k == REQ_MAX - 1) ? 32'h1 : 32'h0);
        end
        chk("com0_ferr_cnt", 32'(ferr_cnt - e0), 32'd5);
        chk("com0_md_kept", cfg_md_id, 32'hDEF0_9ABC);

        build(8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h00);
        send_frame(FL);
        idle(3);
        chk("recov_md_id", cfg_md_id, 32'h5678_1234);
        chk("recov_req_fail", 32'(cfg_req_fail), 32'h1);

        // ---------------- SOF and EOF on one byte ----------------
        e0 = ferr_cnt;
        send_byte(1'b1, 1'b1, 8'h12);
        idle(3);
        chk("one_ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
        chk("one_code", 32'(cfg_err_code), 32'd1);

        // ---------------- self_id_err suppresses trigger ----------------
        self_id_err = 1'b1;
        idle(3);
        build(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h00);
        t0 = trig_cnt;
        send_frame(FL);
        idle(3);
        chk("sid_md_id", cfg_md_id, 32'hDEF0_9ABC);
        chk("sid_done", 32'(cfg_done), 32'h1);
        chk("sid_trig_cnt", 32'(trig_cnt - t0), 32'd0);
        self_id_err = 1'b0;
        idle(3);

        // ---------------- reset mid-frame ----------------
        build(8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h00);
        for (int i = 0; i < 5; i++) send_byte(i == 0, 1'b0, fr[i]);
        #2 rst_sys = 1'b1;
        #1;
        chk("mrst_md_id", cfg_md_id, 32'h0);
        chk("mrst_done", 32'(cfg_done), 32'h0);
        chk("mrst_req_fail", 32'(cfg_req_fail), 32'h0);
        chk("mrst_code", 32'(cfg_err_code), 32'h0);
        chk("mrst_chn", 32'(cfg_chn_enable), 32'h0);
        idle(2);
        rst_sys = 1'b0;
        idle(1);
        e0 = ferr_cnt; t0 = trig_cnt;
        for (int i = 5; i < FL; i++) send_byte(1'b0, i == FL - 1, fr[i]);
        idle(3);
        chk("mrst_tail_ignored", 32'(ferr_cnt - e0), 32'd0);
        chk("mrst_tail_done", 32'(cfg_done), 32'h0);
        send_frame(FL);
        idle(3);
        chk("mrst_after_md", cfg_md_id, 32'h5678_1234);
        chk("mrst_after_trig", 32'(trig_cnt - t0), 32'd1);
        chk("mrst_after_req_fail", 32'(cfg_req_fail), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
